// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared state, opcode, funct and control-code definitions for the multicycle CPU
package mc_pkg;

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_EXE  = 4'd2,
    S_BEQ  = 4'd3,
    S_ADDR = 4'd4,
    S_MEM  = 4'd5,
    S_WB   = 4'd6,
    S_WBL  = 4'd7,
    S_HALT = 4'd8
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;

  localparam logic [1:0] EXT_SA   = 2'b00;
  localparam logic [1:0] EXT_ZERO = 2'b01;
  localparam logic [1:0] EXT_SIGN = 2'b10;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Anything without an immediate (j, R-type other than sll) falls back to EXT_SA.
  function automatic logic [1:0] ext_mode(input logic [5:0] op);
    case (op)
      OP_ORI:                          ext_mode = EXT_ZERO;
      OP_ADDI, OP_LW, OP_SW, OP_BEQ:   ext_mode = EXT_SIGN;
      default:                         ext_mode = EXT_SA;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// rtl/mc_alu_decode.sv - maps opcode/funct to the ALU operation code
module mc_alu_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] aluop,
  output logic       funct_ok
);

  always_comb begin
    aluop    = ALU_ADD;
    funct_ok = 1'b0;
    case (op)
      OP_RTYPE: begin
        funct_ok = 1'b1;
        case (funct)
          FN_ADD:  aluop = ALU_ADD;
          FN_SUB:  aluop = ALU_SUB;
          FN_AND:  aluop = ALU_AND;
          FN_OR:   aluop = ALU_OR;
          FN_SLT:  aluop = ALU_SLT;
          FN_SLL:  aluop = ALU_SLL;
          default: funct_ok = 1'b0;
        endcase
      end
      OP_ORI:  aluop = ALU_OR;
      OP_BEQ:  aluop = ALU_SUB;
      default: aluop = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control FSM with combinational strobe decode
module multicycle_control
  import mc_pkg::*;
#(
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWre,
  output logic       IRWre,
  output logic       mRD,
  output logic       mWR,
  output logic       RegWre,
  output logic       RegDst,
  output logic       WrRegDSrc,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic [1:0] ExtSel,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic [3:0] state
);

  state_t     r_state;
  logic [5:0] r_op;
  logic [5:0] r_funct;

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic [2:0] w_aluop;
  logic       w_funct_ok;
  logic       w_is_r;
  logic       w_is_imm;
  logic       w_known;

  // In ID the instruction register is still live; afterwards only the latched copy is trusted.
  assign w_op     = (r_state == S_ID) ? op    : r_op;
  assign w_funct  = (r_state == S_ID) ? funct : r_funct;
  assign w_is_r   = (w_op == OP_RTYPE);
  assign w_is_imm = (w_op == OP_ADDI) || (w_op == OP_ORI) || (w_op == OP_LW) || (w_op == OP_SW);
  assign w_known  = (w_op == OP_J) || (w_op == HALT_OP) || (w_op == OP_BEQ) || w_is_r || w_is_imm;

  mc_alu_decode u_alu_decode (
    .op       (w_op),
    .funct    (w_funct),
    .aluop    (w_aluop),
    .funct_ok (w_funct_ok)
  );

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state <= S_IF;
      r_op    <= 6'd0;
      r_funct <= 6'd0;
    end else begin
      case (r_state)
        S_IF: r_state <= S_ID;
        S_ID: begin
          r_op    <= op;
          r_funct <= funct;
          if (op == OP_J)                                        r_state <= S_IF;
          else if (op == HALT_OP)                                r_state <= S_HALT;
          else if (op == OP_BEQ)                                 r_state <= S_BEQ;
          else if (op == OP_LW || op == OP_SW)                   r_state <= S_ADDR;
          else if (op == OP_RTYPE || op == OP_ADDI || op == OP_ORI) r_state <= S_EXE;
          else                                                   r_state <= S_IF;
        end
        S_EXE:  r_state <= S_WB;
        S_WB:   r_state <= S_IF;
        S_BEQ:  r_state <= S_IF;
        S_ADDR: r_state <= S_MEM;
        S_MEM:  r_state <= (r_op == OP_LW) ? S_WBL : S_IF;
        S_WBL:  r_state <= S_IF;
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_IF;
      endcase
    end
  end

  assign state = r_state;

  // Outputs are gated by RST_n so a reset clears every strobe without waiting for a clock edge.
  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    RegWre    = 1'b0;
    RegDst    = 1'b0;
    WrRegDSrc = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = EXT_SA;
    ALUOp     = ALU_ADD;
    PCSrc     = PC_NEXT;
    if (RST_n) begin
      if (r_state != S_IF && r_state != S_HALT) begin
        ExtSel  = ext_mode(w_op);
        ALUOp   = w_aluop;
        ALUSrcA = w_is_r && (w_funct == FN_SLL);
        ALUSrcB = w_is_imm;
      end
      case (r_state)
        S_IF: IRWre = 1'b1;
        S_ID: begin
          if (w_op == OP_J) begin
            PCWre = 1'b1;
            PCSrc = PC_JUMP;
          end else if (!w_known) begin
            PCWre = 1'b1;
          end
        end
        S_BEQ: begin
          PCWre = 1'b1;
          PCSrc = zero ? PC_BRANCH : PC_NEXT;
        end
        S_MEM: begin
          mRD   = (w_op == OP_LW);
          mWR   = (w_op == OP_SW);
          PCWre = (w_op == OP_SW);
        end
        S_WB: begin
          PCWre  = 1'b1;
          RegDst = w_is_r;
          RegWre = w_is_r ? w_funct_ok : 1'b1;
        end
        S_WBL: begin
          PCWre     = 1'b1;
          RegWre    = 1'b1;
          WrRegDSrc = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
